// File: rtl/xdma_pkg.sv
// xdma_pkg -- shared types and constants for the XDMA burst scheduler.
//   burst_desc_t : AXI AW fields {id, addr, len, size, burst, cache} plus
//                  W-side fields {num_beats, is_single, is_write_data}.
//                  addr/id fields are sized for the widest supported config;
//                  narrower configs zero-extend into them.
//   PageBytes    : AXI 4 KiB boundary size.
//   beat_size()  : AXI AxSIZE encoding for a given data width.
package xdma_pkg;

  localparam int unsigned PageBytes = 4096;
  localparam int unsigned DescAddrW = 64;
  localparam int unsigned DescIdW   = 8;
  localparam logic [1:0]  BurstIncr = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1,
    DRAIN = 2'd2
  } xdma_state_e;

  typedef struct packed {
    logic [DescIdW-1:0]   id;
    logic [DescAddrW-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [3:0]           cache;
    logic [8:0]           num_beats;
    logic                 is_single;
    logic                 is_write_data;
  } burst_desc_t;

  function automatic logic [2:0] beat_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/xdma_burst_len_calc.sv
// xdma_burst_len_calc -- combinational burst-length selection.
//   addr_i  : current burst start address (beat aligned)
//   rem_i   : beats still to be issued
//   beats_o : b = min(rem, MaxBurstBeats[, beats left in the 4 KiB page])
// The page term is active only when XDMA_4K_BOUNDARY_EN is defined.
module xdma_burst_len_calc
  import xdma_pkg::*;
#(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 512,
  parameter int unsigned MaxBurstBeats = 256,
  parameter int unsigned LenWidth      = 32
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [LenWidth-1:0]  rem_i,
  output logic [8:0]           beats_o
);

  localparam int unsigned ByteShift = $clog2(DataWidth / 8);
  localparam int unsigned PageShift = $clog2(PageBytes);
  localparam int unsigned PageBeats = PageBytes / (DataWidth / 8);

`ifdef XDMA_4K_BOUNDARY_EN
  localparam logic UsePage = 1'b1;
`else
  localparam logic UsePage = 1'b0;
`endif

  logic [9:0] to_page;
  logic [9:0] lim;
  logic       unused_addr;

  // Beats from addr up to (not past) the next page boundary: 1..PageBeats.
  assign to_page     = 10'(PageBeats) - 10'(addr_i[PageShift-1:ByteShift]);
  assign unused_addr = ^{addr_i[AddrWidth-1:PageShift], addr_i[ByteShift-1:0]};

  always_comb begin
    lim = 10'(MaxBurstBeats);
    if (UsePage && (to_page < lim)) lim = to_page;
    if ({10'd0, rem_i} < {{LenWidth{1'b0}}, lim}) beats_o = rem_i[8:0];
    else                                          beats_o = lim[8:0];
  end

endmodule

// File: rtl/xdma_burst_scheduler.sv
// xdma_burst_scheduler -- splits a beat-counted write transfer into AXI INCR
// bursts and tracks W beats until the whole transfer has drained.
// Ports:
//   clk_i, rst_ni                : clock, async active-low reset
//   req_valid_i/req_ready_o      : transfer request handshake
//   req_addr_i/beats_i/id_i      : start address (beat aligned), beats, AXI id
//   burst_valid_o/burst_ready_i  : burst descriptor handshake
//   burst_o                      : burst descriptor (zero when not offering)
//   w_beat_i                     : one W handshake completed
//   busy_o                       : transfer in progress
//   done_o                       : one-cycle completion pulse
// Config: define XDMA_4K_BOUNDARY_EN to keep bursts inside 4 KiB pages.
module xdma_burst_scheduler
  import xdma_pkg::*;
#(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 512,
  parameter int unsigned MaxBurstBeats = 256,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned IdWidth       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [LenWidth-1:0]  req_beats_i,
  input  logic [IdWidth-1:0]   req_id_i,
  output logic                 burst_valid_o,
  input  logic                 burst_ready_i,
  output burst_desc_t          burst_o,
  input  logic                 w_beat_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned ByteShift = $clog2(DataWidth / 8);

  xdma_state_e          state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [LenWidth-1:0]  rem_q;
  logic [LenWidth-1:0]  total_q;
  logic [LenWidth-1:0]  cnt_q;
  logic [IdWidth-1:0]   id_q;
  logic [8:0]           b;
  logic                 last_beat;

  xdma_burst_len_calc #(
    .AddrWidth    (AddrWidth),
    .DataWidth    (DataWidth),
    .MaxBurstBeats(MaxBurstBeats),
    .LenWidth     (LenWidth)
  ) u_len_calc (
    .addr_i (addr_q),
    .rem_i  (rem_q),
    .beats_o(b)
  );

  assign req_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign burst_valid_o = (state_q == SPLIT);
  // A beat landing in the completion cycle counts toward the total.
  assign last_beat     = ((cnt_q + LenWidth'(w_beat_i)) == total_q);
  assign done_o        = (state_q == DRAIN) && last_beat;

  // Descriptor is a pure function of registered state, so it cannot move
  // while a stalled burst is being offered.
  always_comb begin
    burst_o = '0;
    if (state_q == SPLIT) begin
      burst_o.id            = DescIdW'(id_q);
      burst_o.addr          = DescAddrW'(addr_q);
      burst_o.len           = 8'(b - 9'd1);
      burst_o.size          = beat_size(DataWidth);
      burst_o.burst         = BurstIncr;
      burst_o.cache         = 4'd0;
      burst_o.num_beats     = b;
      burst_o.is_single     = (b == 9'd1);
      burst_o.is_write_data = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      total_q <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            rem_q   <= req_beats_i;
            total_q <= req_beats_i;
            id_q    <= req_id_i;
            cnt_q   <= '0;
            state_q <= (req_beats_i != '0) ? SPLIT : DRAIN;
          end
        end
        SPLIT: begin
          if (w_beat_i) cnt_q <= cnt_q + 1'b1;
          if (burst_ready_i) begin
            // Modulo wrap at 2^AddrWidth is intentional.
            addr_q <= addr_q + (AddrWidth'(b) << ByteShift);
            rem_q  <= rem_q - LenWidth'(b);
            if (rem_q == LenWidth'(b)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_beat_i) cnt_q <= cnt_q + 1'b1;
          if (last_beat) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xdma_burst_scheduler.sv
module tb_xdma_burst_scheduler;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  req_valid_i = 1'b0;
  logic                  req_ready_o;
  logic [47:0]           req_addr_i = '0;
  logic [31:0]           req_beats_i = '0;
  logic [3:0]            req_id_i = '0;
  logic                  burst_valid_o;
  logic                  burst_ready_i = 1'b0;
  xdma_pkg::burst_desc_t burst_o;
  logic                  w_beat_i = 1'b0;
  logic                  busy_o;
  logic                  done_o;

  always #5 clk_i = ~clk_i;

  xdma_burst_scheduler dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_beats_i  (req_beats_i),
    .req_id_i     (req_id_i),
    .burst_valid_o(burst_valid_o),
    .burst_ready_i(burst_ready_i),
    .burst_o      (burst_o),
    .w_beat_i     (w_beat_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [47:0] addr;
    int          b;
  } exp_t;

  typedef struct {
    logic [47:0] addr;
    int          beats;
    int          stall;
    int          nb;
    logic [47:0] first_addr;
    int          first_len;
    logic [47:0] last_addr;
    int          last_len;
  } vec_t;

  // Observations from the most recent transfer, taken from DUT outputs.
  int          obs_n;
  int          obs_busy;
  logic [47:0] obs_first_addr, obs_last_addr;
  int          obs_first_len, obs_last_len;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference burst length: min(remaining, 256 beats[, beats to 4 KiB page]).
  function automatic int model_b(input logic [47:0] a, input int rem);
    int b;
    b = (rem < 256) ? rem : 256;
`ifdef XDMA_4K_BOUNDARY_EN
    begin
      int pg;
      pg = (4096 - int'(a[11:0])) / 64;
      if (pg < b) b = pg;
    end
`endif
    return b;
  endfunction

  function automatic xdma_pkg::burst_desc_t exp_desc(input logic [47:0] a, input int b,
                                                     input logic [3:0] id);
    xdma_pkg::burst_desc_t d;
    d               = '0;
    d.id            = 8'(id);
    d.addr          = 64'(a);
    d.len           = 8'(b - 1);
    d.size          = 3'd6;
    d.burst         = 2'b01;
    d.cache         = 4'd0;
    d.num_beats     = 9'(b);
    d.is_single     = (b == 1);
    d.is_write_data = 1'b1;
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      req_valid_i   = 1'b0;
      w_beat_i      = 1'b1;
      burst_ready_i = 1'($urandom_range(1));
      #1;
      chk("idle_busy", busy_o, 1'b0);
      chk("idle_valid", burst_valid_o, 1'b0);
      chk("idle_done", done_o, 1'b0);
      chk("idle_ready", req_ready_o, 1'b1);
    end
  endtask

  // One complete transfer, checked cycle by cycle against the queue model.
  task automatic run_xfer(input logic [47:0] a, input int beats, input logic [3:0] id,
                          input int rdy_pct, input int w_pct, input int stall, input bit hold);
    exp_t                  q[$];
    logic [47:0]           ma;
    int                    rem, issued, w_sent, cyc;
    bit                    exp_done, fin, prev_stall;
    xdma_pkg::burst_desc_t prev;
    ma  = a;
    rem = beats;
    while (rem > 0) begin
      int b;
      b = model_b(ma, rem);
      q.push_back('{ma, b});
      ma  = ma + 48'(b * 64);
      rem = rem - b;
    end
    obs_n = 0; obs_busy = 0;
    obs_first_addr = '0; obs_last_addr = '0; obs_first_len = 0; obs_last_len = 0;

    @(negedge clk_i);
    req_valid_i   = 1'b1;
    req_addr_i    = a;
    req_beats_i   = 32'(beats);
    req_id_i      = id;
    burst_ready_i = 1'b0;
    w_beat_i      = 1'($urandom_range(1));   // must be ignored in IDLE
    #1;
    chk("accept_ready", req_ready_o, 1'b1);
    chk("accept_busy", busy_o, 1'b0);

    issued = 0; w_sent = 0; cyc = 0; fin = 0; prev_stall = 0; prev = '0;
    while (!fin) begin
      @(negedge clk_i);
      req_valid_i   = hold;
      burst_ready_i = (cyc >= stall) && ($urandom_range(99) < rdy_pct);
      w_beat_i      = (w_sent < issued) && ($urandom_range(99) < w_pct);
      #1;
      exp_done = (q.size() == 0) && (w_sent + int'(w_beat_i) == beats);
      chk("busy", busy_o, 1'b1);
      chk("req_ready_busy", req_ready_o, 1'b0);
      chk("burst_valid", burst_valid_o, q.size() != 0);
      chk("done", done_o, exp_done);
      if (q.size() != 0) chk("burst_desc", burst_o, exp_desc(q[0].addr, q[0].b, id));
      if (prev_stall) chk("stall_hold", burst_o, prev);
      prev_stall = burst_valid_o && !burst_ready_i;
      prev       = burst_o;
      obs_busy++;
      if (burst_valid_o && burst_ready_i && q.size() != 0) begin
        if (obs_n == 0) begin
          obs_first_addr = burst_o.addr[47:0];
          obs_first_len  = int'(burst_o.len);
        end
        obs_last_addr = burst_o.addr[47:0];
        obs_last_len  = int'(burst_o.len);
        obs_n++;
        issued += q[0].b;
        void'(q.pop_front());
      end
      if (w_beat_i) w_sent++;
      cyc++;
      if (exp_done) fin = 1;
      else if (cyc > 3000) begin
        n_chk++;
        n_err++;
        $display("FAIL timeout: transfer at %0h still busy after %0d cycles, required done", a, cyc);
        fin = 1;
      end
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{48'h0,   16,  0, 1, 48'h0,   15, 48'h0,   15};
    tbl[3] = '{48'h0,   0,   0, 0, 48'h0,   0,  48'h0,   0};
    tbl[4] = '{48'h40,  1,   0, 1, 48'h40,  0,  48'h40,  0};
`ifdef XDMA_4K_BOUNDARY_EN
    tbl[1] = '{48'hFC0, 4,   0, 2, 48'hFC0, 0,  48'h1000, 2};
    tbl[2] = '{48'h0,   300, 5, 5, 48'h0,   63, 48'h4000, 43};
    tbl[5] = '{48'h7C0, 256, 2, 5, 48'h7C0, 32, 48'h4000, 30};
`else
    tbl[1] = '{48'hFC0, 4,   0, 1, 48'hFC0, 3,   48'hFC0,  3};
    tbl[2] = '{48'h0,   300, 5, 2, 48'h0,   255, 48'h4000, 43};
    tbl[5] = '{48'h7C0, 256, 2, 1, 48'h7C0, 255, 48'h7C0,  255};
`endif

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_valid", burst_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_burst", burst_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_ready", req_ready_o, 1'b1);
    idle(2);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_xfer(tbl[i].addr, tbl[i].beats, 4'(i + 9), 100, 100, tbl[i].stall, 1'b0);
      chk("tbl_nbursts", 32'(obs_n), 32'(tbl[i].nb));
      if (tbl[i].nb > 0) begin
        chk("tbl_first_addr", obs_first_addr, tbl[i].first_addr);
        chk("tbl_first_len", 32'(obs_first_len), 32'(tbl[i].first_len));
        chk("tbl_last_addr", obs_last_addr, tbl[i].last_addr);
        chk("tbl_last_len", 32'(obs_last_len), 32'(tbl[i].last_len));
      end else begin
        chk("tbl_zero_busy_cycles", 32'(obs_busy), 32'd1);
      end
      idle(1);
    end

    // Back-to-back: request held valid through the first transfer; the second
    // must be accepted in the cycle right after done_o.
    run_xfer(48'h2000, 20, 4'h3, 100, 100, 0, 1'b1);
    run_xfer(48'h3000, 5,  4'h4, 100, 100, 0, 1'b0);
    idle(1);

    // Reset in the middle of SPLIT abandons the transfer silently.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 48'h100; req_beats_i = 32'd64; req_id_i = 4'h5;
    burst_ready_i = 1'b0; w_beat_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #1;
    chk("mid_split_valid", burst_valid_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", burst_valid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_done", done_o, 1'b0);
    chk("mid_rst_burst", burst_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(3);

    // Randomized transfers, including addresses near the top of the space.
    for (int i = 0; i < 30; i++) begin
      logic [47:0] a;
      a = {16'($urandom), $urandom};
      if (i % 5 == 0) a = 48'hFFFF_FFFF_F000 | 48'($urandom_range(4095));
      a[5:0] = 6'd0;
      run_xfer(a, $urandom_range(300), 4'($urandom), $urandom_range(40, 100),
               $urandom_range(50, 100), $urandom_range(3), 1'($urandom_range(1)));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
